// File: rtl/sound_pit.sv
// Three-channel 8253-style interval timer (binary, GATE high, modes 0/2/3) for the RK86 beeper.
// The OR of the channel outputs is registered onto pulse for the PWM sound codec.
module sound_pit (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       cs,
  input  logic       wr,
  input  logic       rd,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [2:0] out,
  output logic       pulse
);

  localparam int unsigned NCH = 3;
  localparam int unsigned CW  = 16;

  localparam logic [1:0] MODE0 = 2'd0;
  localparam logic [1:0] MODE2 = 2'd2;
  localparam logic [1:0] MODE3 = 2'd3;

  localparam logic [1:0] RW_LATCH = 2'd0;
  localparam logic [1:0] RW_LSB   = 2'd1;
  localparam logic [1:0] RW_MSB   = 2'd2;
  localparam logic [1:0] RW_WORD  = 2'd3;

  logic [1:0]     mode_q   [NCH];
  logic [1:0]     mode_d   [NCH];
  logic [1:0]     rw_q     [NCH];
  logic [1:0]     rw_d     [NCH];
  logic [CW-1:0]  cnt_q    [NCH];
  logic [CW-1:0]  cnt_d    [NCH];
  logic [CW-1:0]  reload_q [NCH];
  logic [CW-1:0]  reload_d [NCH];
  logic [CW-1:0]  latch_q  [NCH];
  logic [CW-1:0]  latch_d  [NCH];
  logic [7:0]     lsb_q    [NCH];
  logic [7:0]     lsb_d    [NCH];
  logic [NCH-1:0] run_q, run_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] wflip_q, wflip_d;
  logic [NCH-1:0] rflip_q, rflip_d;
  logic [NCH-1:0] latched_q, latched_d;
  logic [NCH-1:0] out_q, out_d;
  logic [7:0]     dout_q, dout_d;
  logic           pulse_q;

  logic           wr_en_c, rd_en_c;
  logic [NCH-1:0] sel_c, ctrl_hit_c, latch_hit_c, cw_hit_c, complete_c, restart_c;
  logic [CW-1:0]  new_n_c [NCH];
  logic [1:0]     mode_dec_c;
  logic [CW-1:0]  rd_src_c;

  // Mode 3 half-period load: odd N splits into (N+1)/2 high and (N-1)/2 low ticks.
  function automatic logic [CW-1:0] half_load(input logic [CW-1:0] n, input logic hi);
    if (!n[0]) return n;
    return hi ? n + 16'd1 : n - 16'd1;
  endfunction

  // Bus decode: which channel each write hits and whether it completes a count.
  always_comb begin
    wr_en_c    = cs & wr;
    rd_en_c    = cs & rd & ~wr;
    mode_dec_c = (din[2:1] == 2'b10) ? MODE2 : (din[2:1] == 2'b11) ? MODE3 : MODE0;
    for (int i = 0; i < int'(NCH); i++) begin
      sel_c[i]       = wr_en_c && (addr == 2'd3) && (din[7:6] == 2'(i));
      ctrl_hit_c[i]  = sel_c[i] && (din[5:4] != RW_LATCH);
      latch_hit_c[i] = sel_c[i] && (din[5:4] == RW_LATCH);
      cw_hit_c[i]    = wr_en_c && (addr == 2'(i));
      complete_c[i]  = cw_hit_c[i] && ((rw_q[i] != RW_WORD) || wflip_q[i]);
      restart_c[i]   = complete_c[i] && ((mode_q[i] == MODE0) || !run_q[i]);
      case (rw_q[i])
        RW_LSB:  new_n_c[i] = {8'h00, din};
        RW_MSB:  new_n_c[i] = {din, 8'h00};
        default: new_n_c[i] = {din, lsb_q[i]};
      endcase
    end
  end

  // Channel next-state: control write, count write, load and counting per ce.
  always_comb begin
    dout_d    = dout_q;
    rd_src_c  = '0;
    run_d     = run_q;
    pend_d    = pend_q;
    wflip_d   = wflip_q;
    rflip_d   = rflip_q;
    latched_d = latched_q;
    out_d     = out_q;
    for (int i = 0; i < int'(NCH); i++) begin
      mode_d[i]   = mode_q[i];
      rw_d[i]     = rw_q[i];
      cnt_d[i]    = cnt_q[i];
      reload_d[i] = reload_q[i];
      latch_d[i]  = latch_q[i];
      lsb_d[i]    = lsb_q[i];

      if (ctrl_hit_c[i]) begin
        rw_d[i]    = din[5:4];
        mode_d[i]  = mode_dec_c;
        run_d[i]   = 1'b0;
        pend_d[i]  = 1'b0;
        wflip_d[i] = 1'b0;
        rflip_d[i] = 1'b0;
        out_d[i]   = (mode_dec_c != MODE0);
      end else begin
        if (latch_hit_c[i] && !latched_q[i]) begin
          latch_d[i]   = cnt_q[i];
          latched_d[i] = 1'b1;
        end
        if (cw_hit_c[i] && !complete_c[i]) begin
          lsb_d[i]   = din;
          wflip_d[i] = 1'b1;
        end
        if (complete_c[i]) begin
          wflip_d[i]  = 1'b0;
          reload_d[i] = new_n_c[i];
        end
        // A running mode 2/3 channel keeps its period; the new N waits for its reload.
        if (restart_c[i]) begin
          pend_d[i] = 1'b1;
          run_d[i]  = 1'b0;
          if (mode_q[i] == MODE0) out_d[i] = 1'b0;
        end else if (ce) begin
          if (pend_q[i]) begin
            pend_d[i] = 1'b0;
            run_d[i]  = 1'b1;
            case (mode_q[i])
              MODE3: begin
                cnt_d[i] = half_load(reload_q[i], 1'b1);
                out_d[i] = 1'b1;
              end
              MODE2: begin
                cnt_d[i] = reload_q[i];
                out_d[i] = 1'b1;
              end
              default: cnt_d[i] = reload_q[i];
            endcase
          end else if (run_q[i]) begin
            case (mode_q[i])
              MODE3: begin
                if (cnt_q[i] == 16'd2) begin
                  out_d[i] = (reload_q[i] == 16'd1) || !out_q[i];
                  cnt_d[i] = half_load(reload_q[i], (reload_q[i] == 16'd1) || !out_q[i]);
                end else begin
                  cnt_d[i] = cnt_q[i] - 16'd2;
                end
              end
              MODE2: begin
                if (cnt_q[i] == 16'd1) begin
                  cnt_d[i] = reload_q[i];
                  out_d[i] = 1'b1;
                end else begin
                  cnt_d[i] = cnt_q[i] - 16'd1;
                  out_d[i] = (cnt_q[i] != 16'd2);
                end
              end
              default: begin
                cnt_d[i] = cnt_q[i] - 16'd1;
                if (cnt_q[i] == 16'd1) out_d[i] = 1'b1;
              end
            endcase
          end
        end
      end
    end

    // Read path: latch takes priority over the live count; RW picks the byte order.
    if (rd_en_c) begin
      if (addr == 2'd3) begin
        dout_d = 8'hFF;
      end else begin
        for (int i = 0; i < int'(NCH); i++) begin
          if (addr == 2'(i)) begin
            rd_src_c = latched_q[i] ? latch_q[i] : cnt_q[i];
            case (rw_q[i])
              RW_MSB: begin
                dout_d       = rd_src_c[15:8];
                latched_d[i] = 1'b0;
              end
              RW_WORD: begin
                dout_d     = rflip_q[i] ? rd_src_c[15:8] : rd_src_c[7:0];
                rflip_d[i] = !rflip_q[i];
                if (rflip_q[i]) latched_d[i] = 1'b0;
              end
              default: begin
                dout_d       = rd_src_c[7:0];
                latched_d[i] = 1'b0;
              end
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NCH); i++) begin
        mode_q[i]   <= MODE0;
        rw_q[i]     <= RW_WORD;
        cnt_q[i]    <= '0;
        reload_q[i] <= '0;
        latch_q[i]  <= '0;
        lsb_q[i]    <= '0;
      end
      run_q     <= '0;
      pend_q    <= '0;
      wflip_q   <= '0;
      rflip_q   <= '0;
      latched_q <= '0;
      out_q     <= '0;
      dout_q    <= '0;
      pulse_q   <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NCH); i++) begin
        mode_q[i]   <= mode_d[i];
        rw_q[i]     <= rw_d[i];
        cnt_q[i]    <= cnt_d[i];
        reload_q[i] <= reload_d[i];
        latch_q[i]  <= latch_d[i];
        lsb_q[i]    <= lsb_d[i];
      end
      run_q     <= run_d;
      pend_q    <= pend_d;
      wflip_q   <= wflip_d;
      rflip_q   <= rflip_d;
      latched_q <= latched_d;
      out_q     <= out_d;
      dout_q    <= dout_d;
      pulse_q   <= |out_q;
    end
  end

  assign dout  = dout_q;
  assign out   = out_q;
  assign pulse = pulse_q;

endmodule

// File: tb/tb_sound_pit.sv
// Bench for sound_pit: a tick-level reference model feeds a scoreboard queue that a
// negedge monitor drains against out, pulse and dout.
module tb_sound_pit;

  logic       clk = 1'b0;
  logic       reset, ce, cs, wr, rd;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic [2:0] out;
  logic       pulse;

  always #5 clk = ~clk;

  sound_pit dut (
    .clk  (clk),
    .reset(reset),
    .ce   (ce),
    .cs   (cs),
    .wr   (wr),
    .rd   (rd),
    .addr (addr),
    .din  (din),
    .dout (dout),
    .out  (out),
    .pulse(pulse)
  );

  typedef struct packed {
    logic [2:0] out;
    logic       pulse;
    logic [7:0] dout;
    logic       dk;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  // Reference model: mode 0 as elapsed ticks, mode 2 as phase within period,
  // mode 3 as ticks remaining in the current half period.
  int       m_mode[3], m_rw[3], m_n[3], m_lsb[3], m_latch[3], m_cnt[3];
  int       m_e[3], m_p[3], m_ncur[3], m_rem[3];
  bit       m_run[3], m_pend[3], m_wflip[3], m_rflip[3], m_latched[3];
  bit       m_latch_known[3], m_cnt_known[3];
  bit [2:0] m_out;
  bit       m_pulse;
  int       m_dout;
  bit       m_dout_known;

  function automatic int eff(input int n);
    return (n == 0) ? 65536 : n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_mode[i] = 0; m_rw[i] = 3; m_n[i] = 0; m_lsb[i] = 0; m_latch[i] = 0; m_cnt[i] = 0;
      m_e[i] = 0; m_p[i] = 0; m_ncur[i] = 1; m_rem[i] = 1;
      m_run[i] = 0; m_pend[i] = 0; m_wflip[i] = 0; m_rflip[i] = 0; m_latched[i] = 0;
      m_latch_known[i] = 1; m_cnt_known[i] = 1;
    end
    m_out = 3'b000; m_pulse = 0; m_dout = 0; m_dout_known = 1;
  endtask

  task automatic model_load(input int i);
    m_run[i] = 1; m_pend[i] = 0;
    case (m_mode[i])
      3: begin m_rem[i] = (eff(m_n[i]) + 1) / 2; m_out[i] = 1; m_cnt_known[i] = 0; end
      2: begin
        m_ncur[i] = eff(m_n[i]); m_p[i] = 0; m_cnt[i] = m_n[i]; m_cnt_known[i] = 1; m_out[i] = 1;
      end
      default: begin m_e[i] = 0; m_cnt[i] = m_n[i]; m_cnt_known[i] = 1; end
    endcase
  endtask

  task automatic model_tick(input int i);
    case (m_mode[i])
      3: begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_out[i] = (m_n[i] == 1) ? 1'b1 : !m_out[i];
          m_rem[i] = m_out[i] ? (eff(m_n[i]) + 1) / 2 : eff(m_n[i]) / 2;
        end
      end
      2: begin
        if (m_p[i] == m_ncur[i] - 1) begin m_p[i] = 0; m_ncur[i] = eff(m_n[i]); end
        else m_p[i]++;
        m_cnt[i] = (m_ncur[i] - m_p[i]) & 16'hFFFF;
        m_out[i] = (m_ncur[i] == 1) || (m_p[i] != m_ncur[i] - 1);
      end
      default: begin
        m_e[i]++;
        m_cnt[i] = (m_n[i] - m_e[i]) & 16'hFFFF;
        if (m_e[i] >= eff(m_n[i])) m_out[i] = 1;
      end
    endcase
  endtask

  task automatic model_step(input bit rst, input bit c, input bit s, input bit w, input bit r,
                            input int a, input int d);
    bit pulse_n, wen, ren, complete, restart;
    int src, newn, mm;
    bit sk;
    if (rst) begin model_reset(); return; end
    pulse_n = |m_out;
    wen = s && w;
    ren = s && r && !w;
    if (ren) begin
      if (a == 3) begin m_dout = 8'hFF; m_dout_known = 1; end
      else begin
        src = m_latched[a] ? m_latch[a] : m_cnt[a];
        sk  = m_latched[a] ? m_latch_known[a] : m_cnt_known[a];
        if (m_rw[a] == 2) begin m_dout = src >> 8; m_latched[a] = 0; end
        else if (m_rw[a] == 1) begin m_dout = src & 8'hFF; m_latched[a] = 0; end
        else begin
          if (m_rflip[a]) begin m_dout = src >> 8; m_latched[a] = 0; end
          else m_dout = src & 8'hFF;
          m_rflip[a] = !m_rflip[a];
        end
        m_dout_known = sk;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (wen && a == 3 && (d >> 6) == i && ((d >> 4) & 3) != 0) begin
        m_rw[i] = (d >> 4) & 3;
        mm = (d >> 1) & 7;
        m_mode[i] = (mm == 2 || mm == 6) ? 2 : (mm == 3 || mm == 7) ? 3 : 0;
        m_run[i] = 0; m_pend[i] = 0; m_wflip[i] = 0; m_rflip[i] = 0;
        m_out[i] = (m_mode[i] != 0);
        continue;
      end
      if (wen && a == 3 && (d >> 6) == i && !m_latched[i]) begin
        m_latch[i] = m_cnt[i]; m_latch_known[i] = m_cnt_known[i]; m_latched[i] = 1;
      end
      complete = 0; newn = 0;
      if (wen && a == i) begin
        if (m_rw[i] == 3 && !m_wflip[i]) begin m_lsb[i] = d; m_wflip[i] = 1; end
        else begin
          m_wflip[i] = 0; complete = 1;
          newn = (m_rw[i] == 1) ? d : (m_rw[i] == 2) ? (d << 8) : ((d << 8) | m_lsb[i]);
        end
      end
      restart = complete && (m_mode[i] == 0 || !m_run[i]);
      if (restart) begin
        m_n[i] = newn; m_pend[i] = 1; m_run[i] = 0;
        if (m_mode[i] == 0) m_out[i] = 0;
      end else begin
        if (c) begin
          if (m_pend[i]) model_load(i);
          else if (m_run[i]) model_tick(i);
        end
        if (complete) m_n[i] = newn;
      end
    end
    m_pulse = pulse_n;
  endtask

  task automatic drive(input bit rst, input bit c, input bit s, input bit w, input bit r,
                       input int a, input int d);
    exp_t e;
    reset = rst; ce = c; cs = s; wr = w; rd = r; addr = 2'(a); din = 8'(d);
    model_step(rst, c, s, w, r, a, d);
    e.out = m_out; e.pulse = m_pulse; e.dout = 8'(m_dout); e.dk = m_dout_known;
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) drive(0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic wrb(input int a, input int d);
    drive(0, 1, 1, 1, 0, a, d);
  endtask

  task automatic rdb(input int a);
    drive(0, 1, 1, 0, 1, a, 0);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents out/pulse/dout, compare against the queue head.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("out", 16'(out), 16'(mon_e.out));
      check("pulse", 16'(pulse), 16'(mon_e.pulse));
      if (mon_e.dk) check("dout", 16'(dout), 16'(mon_e.dout));
    end
  end

  initial begin
    int r, a, d, k;
    bit c, s;
    reset = 1; ce = 0; cs = 0; wr = 0; rd = 0; addr = 0; din = 0;
    model_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0);
    run(100);

    wrb(3, 8'h36); wrb(0, 8'h0A); wrb(0, 8'h00); run(40);

    wrb(3, 8'h76); wrb(1, 7); wrb(1, 0); run(16);
    wrb(1, 4); wrb(1, 0); run(30);

    wrb(3, 8'hB0); wrb(2, 5); wrb(2, 0); run(9);
    wrb(2, 5); wrb(2, 0); run(10);

    wrb(3, 8'h30); wrb(0, 8'h34); wrb(0, 8'h12); run(30);
    wrb(3, 8'h00); run(20);
    rdb(0); rdb(0); rdb(0); rdb(3); run(3);

    wrb(3, 8'h14); wrb(0, 3); run(15);
    drive(1, 1, 0, 0, 0, 0, 0);
    run(20);
    rdb(0); run(2);

    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 199);
      c = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 15) != 0);
      if (r < 6) begin
        k = $urandom_range(0, 7);
        d = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 4) | (k << 1) | $urandom_range(0, 1);
        drive(0, c, s, 1, 0, 3, d);
      end else if (r < 22) begin
        a = $urandom_range(0, 2);
        d = ($urandom_range(0, 99) < 75) ? $urandom_range(1, 12) : $urandom_range(0, 255);
        drive(0, c, s, 1, ($urandom_range(0, 7) == 0), a, d);
      end else if (r < 34) begin
        drive(0, c, s, 0, 1, $urandom_range(0, 3), 0);
      end else if (r == 199 && $urandom_range(0, 3) == 0) begin
        drive(1, c, 0, 0, 0, 0, 0);
      end else begin
        drive(0, c, 0, 0, 0, 0, 0);
      end
    end

    run(4);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
